// File: rtl/dispatch_sysreg_write_arbiter_if.sv
// ============================================================================
// Module   : dispatch_sysreg_write_arbiter_if
// Brief    : Requester-side request bus and register-bank write bus of the
//            dispatch system-register write arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface dispatch_sysreg_write_arbiter_if #(
    parameter int REQ_N = 3,
    parameter int REG_N = 8,
    parameter int AW    = 3
);
    logic                  iHOLD;
    logic [REQ_N-1:0]      iREQ_VALID;
    logic [REQ_N*AW-1:0]   iREQ_ADDR;
    logic [REQ_N*32-1:0]   iREQ_DATA;
    logic [REQ_N-1:0]      oREQ_ACK;
    logic [REG_N-1:0]      oREGIST_VALID;
    logic [31:0]           oREGIST_DATA;
    logic                  oADDR_ERR;
    logic                  oBUSY;

    // Requesters and the register bank
    modport master (
        output iHOLD, iREQ_VALID, iREQ_ADDR, iREQ_DATA,
        input  oREQ_ACK, oREGIST_VALID, oREGIST_DATA, oADDR_ERR, oBUSY
    );

    // Arbiter
    modport slave (
        input  iHOLD, iREQ_VALID, iREQ_ADDR, iREQ_DATA,
        output oREQ_ACK, oREGIST_VALID, oREGIST_DATA, oADDR_ERR, oBUSY
    );
endinterface

`default_nettype wire

// File: rtl/dispatch_sysreg_write_arbiter.sv
// ============================================================================
// Module   : dispatch_sysreg_write_arbiter
// Brief    : Grants one pending system-register write per two cycles and drives
//            a one-hot strobe plus data into the register bank.
//            Define DISPATCH_SYSREG_ARB_RR_EN for round-robin arbitration;
//            fixed priority (requester 0 highest) otherwise.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dispatch_sysreg_write_arbiter #(
    parameter int REQ_N = 3,
    parameter int REG_N = 8,
    parameter int AW    = 3
) (
    input  wire logic iCLOCK,
    input  wire logic inRESET,
    input  wire logic iRESET_SYNC,
    dispatch_sysreg_write_arbiter_if.slave bus
);

    localparam int c_PW = (REQ_N > 1) ? $clog2(REQ_N) : 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [c_PW-1:0]    w_winner;
    logic               w_grant;
    logic [AW-1:0]      w_addr;
    logic [31:0]        w_data;
    logic               w_in_range;
    logic [REG_N-1:0]   w_strobe;
    logic [REQ_N-1:0]   w_ack;

    logic [REQ_N-1:0]   r_ack;
    logic [REG_N-1:0]   r_regist_valid;
    logic [31:0]        r_regist_data;
    logic               r_addr_err;

    // Requests are only looked at in IDLE, so a stale valid seen during the ack is never re-granted
    assign w_grant = (r_state == S_IDLE) && !bus.iHOLD && (|bus.iREQ_VALID);

`ifdef DISPATCH_SYSREG_ARB_RR_EN
    logic [c_PW-1:0] r_ptr;

    always_comb begin : p_rr_select
        int  v_j;
        logic v_found;
        v_j      = 0;
        v_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < REQ_N; i++) begin
            v_j = int'(r_ptr) + i;
            if (v_j >= REQ_N) v_j = v_j - REQ_N;
            if (!v_found && bus.iREQ_VALID[v_j]) begin
                v_found  = 1'b1;
                w_winner = c_PW'(v_j);
            end
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_ptr <= '0;
        end else if (iRESET_SYNC) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_winner == c_PW'(REQ_N - 1)) ? '0 : w_winner + 1'b1;
        end
    end
`else
    always_comb begin : p_fixed_select
        w_winner = '0;
        for (int i = REQ_N - 1; i >= 0; i--) begin
            if (bus.iREQ_VALID[i]) w_winner = c_PW'(i);
        end
    end
`endif

    assign w_addr     = bus.iREQ_ADDR[int'(w_winner) * AW +: AW];
    assign w_data     = bus.iREQ_DATA[int'(w_winner) * 32 +: 32];
    assign w_in_range = (int'(w_addr) < REG_N);

    always_comb begin : p_decode
        w_strobe = '0;
        w_ack    = '0;
        for (int r = 0; r < REG_N; r++) begin
            w_strobe[r] = w_in_range && (int'(w_addr) == r);
        end
        for (int k = 0; k < REQ_N; k++) begin
            w_ack[k] = (int'(w_winner) == k);
        end
    end

    always_comb begin : p_next_state
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_state <= S_IDLE;
        end else if (iRESET_SYNC) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Strobes are loaded on the grant edge and cleared one cycle later; data holds
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_ack          <= '0;
            r_regist_valid <= '0;
            r_regist_data  <= '0;
            r_addr_err     <= 1'b0;
        end else if (iRESET_SYNC) begin
            r_ack          <= '0;
            r_regist_valid <= '0;
            r_regist_data  <= '0;
            r_addr_err     <= 1'b0;
        end else if (w_grant) begin
            r_ack          <= w_ack;
            r_regist_valid <= w_strobe;
            r_regist_data  <= w_data;
            r_addr_err     <= !w_in_range;
        end else begin
            r_ack          <= '0;
            r_regist_valid <= '0;
            r_addr_err     <= 1'b0;
        end
    end

    assign bus.oREQ_ACK      = r_ack;
    assign bus.oREGIST_VALID = r_regist_valid;
    assign bus.oREGIST_DATA  = r_regist_data;
    assign bus.oADDR_ERR     = r_addr_err;
    assign bus.oBUSY         = (r_state == S_ISSUE);

endmodule

`default_nettype wire

// File: tb/tb_dispatch_sysreg_write_arbiter.sv
// ============================================================================
// Module   : tb_dispatch_sysreg_write_arbiter
// Brief    : Directed self-checking bench; DUT A uses REG_N=8, DUT B REG_N=6.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dispatch_sysreg_write_arbiter;

    logic iCLOCK;
    logic inRESET;
    logic iRESET_SYNC;

    int   n_checks;
    int   n_fail;

    dispatch_sysreg_write_arbiter_if #(.REQ_N(3), .REG_N(8), .AW(3)) bus_a ();
    dispatch_sysreg_write_arbiter_if #(.REQ_N(3), .REG_N(6), .AW(3)) bus_b ();

    dispatch_sysreg_write_arbiter #(.REQ_N(3), .REG_N(8), .AW(3)) u_dut_a (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .iRESET_SYNC (iRESET_SYNC),
        .bus         (bus_a)
    );

    dispatch_sysreg_write_arbiter #(.REQ_N(3), .REG_N(6), .AW(3)) u_dut_b (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .iRESET_SYNC (iRESET_SYNC),
        .bus         (bus_b)
    );

    initial begin
        iCLOCK = 1'b0;
        forever #5 iCLOCK = ~iCLOCK;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic check_idle_a(input string tag);
        check_val({tag, "_ack"},   64'(bus_a.oREQ_ACK),      64'h0);
        check_val({tag, "_valid"}, 64'(bus_a.oREGIST_VALID), 64'h0);
        check_val({tag, "_err"},   64'(bus_a.oADDR_ERR),     64'h0);
        check_val({tag, "_busy"},  64'(bus_a.oBUSY),         64'h0);
    endtask

    logic [2:0]  t2_addr [3];
    logic [31:0] t2_data [3];
    int          t2_exp  [4];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        inRESET     = 1'b0;
        iRESET_SYNC = 1'b0;
        bus_a.iHOLD = 1'b0; bus_a.iREQ_VALID = '0; bus_a.iREQ_ADDR = '0; bus_a.iREQ_DATA = '0;
        bus_b.iHOLD = 1'b0; bus_b.iREQ_VALID = '0; bus_b.iREQ_ADDR = '0; bus_b.iREQ_DATA = '0;

        // Reset state
        #2;
        check_idle_a("rst");
        check_val("rst_data", 64'(bus_a.oREGIST_DATA), 64'h0);
        #10 inRESET = 1'b1;
        tick();

        // 1: single request from requester 1
        bus_a.iREQ_VALID = 3'b010;
        bus_a.iREQ_ADDR  = 9'(2) << 3;
        bus_a.iREQ_DATA  = 96'(32'hDEAD_BEEF) << 32;
        tick();
        check_val("t1_ack",   64'(bus_a.oREQ_ACK),      64'h2);
        check_val("t1_valid", 64'(bus_a.oREGIST_VALID), 64'h04);
        check_val("t1_data",  64'(bus_a.oREGIST_DATA),  64'hDEAD_BEEF);
        check_val("t1_busy",  64'(bus_a.oBUSY),         64'h1);
        check_val("t1_err",   64'(bus_a.oADDR_ERR),     64'h0);
        bus_a.iREQ_VALID = '0;
        tick();
        check_idle_a("t1_after");
        check_val("t1_hold_data", 64'(bus_a.oREGIST_DATA), 64'hDEAD_BEEF);

        // Return the round-robin pointer to 0 before the contention test
        iRESET_SYNC = 1'b1;
        tick();
        iRESET_SYNC = 1'b0;

        // 2: all three requesters valid and held
        t2_addr[0] = 3'd1; t2_addr[1] = 3'd3; t2_addr[2] = 3'd5;
        t2_data[0] = 32'h1111_0000; t2_data[1] = 32'h2222_0001; t2_data[2] = 32'h3333_0002;
`ifdef DISPATCH_SYSREG_ARB_RR_EN
        t2_exp[0] = 0; t2_exp[1] = 1; t2_exp[2] = 2; t2_exp[3] = 0;
`else
        t2_exp[0] = 0; t2_exp[1] = 0; t2_exp[2] = 0; t2_exp[3] = 0;
`endif
        bus_a.iREQ_VALID = 3'b111;
        bus_a.iREQ_ADDR  = {t2_addr[2], t2_addr[1], t2_addr[0]};
        bus_a.iREQ_DATA  = {t2_data[2], t2_data[1], t2_data[0]};
        for (int g = 0; g < 4; g++) begin
            tick();
            check_val($sformatf("t2_ack%0d", g),   64'(bus_a.oREQ_ACK),      64'(3'b001 << t2_exp[g]));
            check_val($sformatf("t2_valid%0d", g), 64'(bus_a.oREGIST_VALID), 64'(8'h01 << t2_addr[t2_exp[g]]));
            check_val($sformatf("t2_data%0d", g),  64'(bus_a.oREGIST_DATA),  64'(t2_data[t2_exp[g]]));
            tick();
            check_val($sformatf("t2_gap%0d", g),   64'(bus_a.oREQ_ACK),      64'h0);
        end
        bus_a.iREQ_VALID = '0;
        tick();

        // 3: out-of-range index on the REG_N=6 instance
        bus_b.iREQ_VALID = 3'b100;
        bus_b.iREQ_ADDR  = 9'(7) << 6;
        bus_b.iREQ_DATA  = 96'(32'hCAFE_0007) << 64;
        tick();
        check_val("t3_ack",   64'(bus_b.oREQ_ACK),      64'h4);
        check_val("t3_err",   64'(bus_b.oADDR_ERR),     64'h1);
        check_val("t3_valid", 64'(bus_b.oREGIST_VALID), 64'h0);
        bus_b.iREQ_VALID = '0;
        tick();
        check_val("t3_err_pulse", 64'(bus_b.oADDR_ERR), 64'h0);
        bus_b.iREQ_VALID = 3'b001;
        bus_b.iREQ_ADDR  = 9'(5);
        bus_b.iREQ_DATA  = 96'(32'h0000_0055);
        tick();
        check_val("t3_top_valid", 64'(bus_b.oREGIST_VALID), 64'h20);
        check_val("t3_top_err",   64'(bus_b.oADDR_ERR),     64'h0);
        bus_b.iREQ_VALID = '0;
        tick();

        // 4: iHOLD for four cycles with requester 0 pending
        bus_a.iHOLD      = 1'b1;
        bus_a.iREQ_VALID = 3'b001;
        bus_a.iREQ_ADDR  = 9'(3);
        bus_a.iREQ_DATA  = 96'(32'h0000_1234);
        for (int h = 0; h < 4; h++) begin
            tick();
            check_val($sformatf("t4_hold_ack%0d", h), 64'(bus_a.oREQ_ACK), 64'h0);
        end
        bus_a.iHOLD = 1'b0;
        tick();
        check_val("t4_ack",   64'(bus_a.oREQ_ACK),      64'h1);
        check_val("t4_valid", 64'(bus_a.oREGIST_VALID), 64'h08);
        check_val("t4_data",  64'(bus_a.oREGIST_DATA),  64'h1234);
        bus_a.iREQ_VALID = '0;
        tick();

        // 5: synchronous reset during ISSUE
        bus_a.iREQ_VALID = 3'b001;
        bus_a.iREQ_ADDR  = 9'(4);
        bus_a.iREQ_DATA  = 96'(32'h0000_5555);
        tick();
        check_val("t5_busy", 64'(bus_a.oBUSY), 64'h1);
        iRESET_SYNC      = 1'b1;
        bus_a.iREQ_VALID = '0;
        tick();
        check_idle_a("t5_rst");
        check_val("t5_data", 64'(bus_a.oREGIST_DATA), 64'h0);
        iRESET_SYNC = 1'b0;
        tick();
        check_val("t5_no_write", 64'(bus_a.oREGIST_VALID), 64'h0);
        bus_a.iREQ_VALID = 3'b111;
        tick();
        check_val("t5_ptr0", 64'(bus_a.oREQ_ACK), 64'h1);
        bus_a.iREQ_VALID = '0;
        tick();

        // 6: asynchronous reset pulse mid-ISSUE
        bus_a.iREQ_VALID = 3'b010;
        bus_a.iREQ_ADDR  = 9'(6) << 3;
        bus_a.iREQ_DATA  = 96'(32'hA5A5_A5A5) << 32;
        tick();
        check_val("t6_valid_pre", 64'(bus_a.oREGIST_VALID), 64'h40);
        #2 inRESET = 1'b0;
        #1;
        check_idle_a("t6_async");
        check_val("t6_data", 64'(bus_a.oREGIST_DATA), 64'h0);
        bus_a.iREQ_VALID = '0;
        #2 inRESET = 1'b1;
        tick();
        check_idle_a("t6_after");
        tick();
        check_val("t6_no_write", 64'(bus_a.oREGIST_VALID), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
